data_sram_responder: RTL

//  Responder (memory) end of the core's SRAM-like data interface. Accepts
//  en / wen[3:0] / addr / wdata from the MEM stage and stores words in an

---
 rtl/data_sram_responder_if.sv | 19 +
 rtl/data_sram_responder.sv | 94 +++++++++
 2 files changed

// File: rtl/data_sram_responder_if.sv
// SRAM-like data bus between the MEM stage (master) and the data memory responder (slave).
// addr_err exists only when SRAM_RESP_ADDR_CHECK_EN is defined.
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
`ifdef SRAM_RESP_ADDR_CHECK_EN
  logic        addr_err;

  modport master (output en, wen, addr, wdata, input rdata, stall, addr_err);
  modport slave  (input en, wen, addr, wdata, output rdata, stall, addr_err);
`else
  modport master (output en, wen, addr, wdata, input rdata, stall);
  modport slave  (input en, wen, addr, wdata, output rdata, stall);
`endif
endinterface

// File: rtl/data_sram_responder.sv
// Data-memory responder: byte-lane writes, registered reads, WAIT_CYCLES stall states per access.
// Optional SRAM_RESP_ADDR_CHECK_EN rejects addresses above the array and flags addr_err.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  data_sram_responder_if.slave bus
);
  localparam int         DEPTH    = 2**ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    addr_hi_nz;
  logic                    oob;
  logic                    stall;
  logic                    commit;
  logic                    wr_ok;

  assign idx        = bus.addr[ADDR_WIDTH+1:2];
  assign addr_hi_nz = |bus.addr[31:ADDR_WIDTH+2];

`ifdef SRAM_RESP_ADDR_CHECK_EN
  logic addr_err_q;
  assign oob          = addr_hi_nz;
  assign bus.addr_err = addr_err_q;
  logic  unused_lo;
  assign unused_lo = ^bus.addr[1:0];
`else
  // Upper address bits alias onto the array; byte offset is resolved upstream via wen.
  logic  unused_bits;
  assign unused_bits = ^{bus.addr[1:0], addr_hi_nz};
  assign oob         = 1'b0;
`endif

  always_comb begin
    stall  = 1'b0;
    commit = 1'b0;
    if (bus.en) begin
      if (WAIT_CYCLES == 0)         commit = 1'b1;
      else if (state_q == S_IDLE)   stall  = 1'b1;
      else if (cnt_q != 4'd0)       stall  = 1'b1;
      else                          commit = 1'b1;
    end
  end

  assign bus.stall = stall;
  assign bus.rdata = rdata_q;
  assign wr_ok     = commit && !rst_i && (bus.wen != 4'b0000) && !oob;

  // Array is never reset so it can map onto a plain SRAM macro.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_ok && bus.wen[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
`ifdef SRAM_RESP_ADDR_CHECK_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.en && WAIT_CYCLES != 0) begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          // Dropping en mid-wait is a flush: back to idle without committing.
          if (!bus.en || cnt_q == 4'd0) state_q <= S_IDLE;
          else                          cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (commit && bus.wen == 4'b0000) rdata_q <= oob ? 32'd0 : mem[idx];
`ifdef SRAM_RESP_ADDR_CHECK_EN
      addr_err_q <= commit && oob;
`endif
    end
  end
endmodule
